// File: rtl/otter_fetch_pkg.sv
// Shared types and constants for the OTTER instruction-fetch front end.
package otter_fetch_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/otter_fetch_queue_if.sv
// Bundle of program-counter, instruction-memory, redirect and decode signals seen by the fetch queue.
interface otter_fetch_queue_if
    import otter_fetch_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = 4
);
    logic [XLEN-1:0]              FQ_PC;
    logic                         FQ_PC_LD;
    logic [XLEN-1:0]              FQ_PC_DIN;
    logic                         FQ_MEM_RDEN;
    logic [XLEN-1:0]              FQ_MEM_DOUT;
    logic                         FQ_REDIR;
    logic [XLEN-1:0]              FQ_REDIR_ADDR;
    logic                         FQ_OUT_VALID;
    logic                         FQ_OUT_READY;
    logic [XLEN-1:0]              FQ_OUT_INSTR;
    logic [XLEN-1:0]              FQ_OUT_PC;
    logic [$clog2(DEPTH+1)-1:0]   FQ_COUNT;

    // The fetch queue is the controlling end.
    modport master (
        input  FQ_PC, FQ_MEM_DOUT, FQ_REDIR, FQ_REDIR_ADDR, FQ_OUT_READY,
        output FQ_PC_LD, FQ_PC_DIN, FQ_MEM_RDEN, FQ_OUT_VALID, FQ_OUT_INSTR, FQ_OUT_PC, FQ_COUNT
    );

    modport slave (
        output FQ_PC, FQ_MEM_DOUT, FQ_REDIR, FQ_REDIR_ADDR, FQ_OUT_READY,
        input  FQ_PC_LD, FQ_PC_DIN, FQ_MEM_RDEN, FQ_OUT_VALID, FQ_OUT_INSTR, FQ_OUT_PC, FQ_COUNT
    );

endinterface

// File: rtl/otter_fetch_fifo.sv
// Circular buffer of fetch entries with push, pop, flush and occupancy count.
module otter_fetch_fifo
    import otter_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_pop_s;

    // Next-state for storage, pointers and count; flush wins over push and pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop_s = pop && (count_q != {CW{1'b0}});
        if (flush) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push, do_pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers, cleared asynchronously including storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    otter_fetch_fifo_chk #(.DEPTH(DEPTH)) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .count (count_q)
    );

endmodule

// File: rtl/otter_fetch_fifo_chk.sv
// Simulation checks for the fetch FIFO.
module otter_fetch_fifo_chk #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);

    // A push into a full queue would overwrite the head entry.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && (count == CW'(DEPTH))))
        else $error("fetch fifo overflow");

endmodule

// File: rtl/otter_fetch_queue.sv
// OTTER fetch front end: drives the program counter, issues memory reads and queues returned words for decode.
module otter_fetch_queue
    import otter_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = XLEN_DEF
) (
    input  logic                FQ_CLK,
    input  logic                FQ_RST_N,
    otter_fetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            pend_vld_q, pend_vld_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            issue_s, push_s, pop_s, out_valid_s;
    logic [CW-1:0]   count_s;
    logic [CW:0]     occ_s;
    fetch_entry_t    head_s, push_data_s;

    // Issue only when the in-flight read is guaranteed a slot; a same-cycle pop is ignored.
    always_comb begin
        occ_s       = {1'b0, count_s} + {{CW{1'b0}}, pend_vld_q};
        out_valid_s = FQ_RST_N && (count_s != {CW{1'b0}}) && !bus.FQ_REDIR;
        issue_s     = FQ_RST_N && !bus.FQ_REDIR && (occ_s < (CW+1)'(DEPTH));
        pop_s       = out_valid_s && bus.FQ_OUT_READY;
        push_s      = pend_vld_q && !bus.FQ_REDIR;
        push_data_s = '{pc: pend_pc_q, instr: bus.FQ_MEM_DOUT};
    end

    // Pending-read next state; a redirect suppresses issue and so drops the in-flight word.
    always_comb begin
        pend_vld_d = issue_s;
        if (issue_s) begin
            pend_pc_d = bus.FQ_PC;
        end else begin
            pend_pc_d = pend_pc_q;
        end
    end

    // Pending-read register.
    always_ff @(posedge FQ_CLK or negedge FQ_RST_N) begin
        if (!FQ_RST_N) begin
            pend_vld_q <= 1'b0;
            pend_pc_q  <= {XLEN{1'b0}};
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

    otter_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (FQ_CLK),
        .rst_n     (FQ_RST_N),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .flush     (bus.FQ_REDIR),
        .head      (head_s),
        .count     (count_s)
    );

    // Counter control and decode-side outputs; everything is held at zero during reset.
    always_comb begin
        if (FQ_RST_N && bus.FQ_REDIR) begin
            bus.FQ_PC_LD    = 1'b1;
            bus.FQ_PC_DIN   = {bus.FQ_REDIR_ADDR[XLEN-1:2], 2'b00};
            bus.FQ_MEM_RDEN = 1'b0;
        end else if (issue_s) begin
            bus.FQ_PC_LD    = 1'b1;
            bus.FQ_PC_DIN   = bus.FQ_PC + XLEN'(INSTR_BYTES);
            bus.FQ_MEM_RDEN = 1'b1;
        end else begin
            bus.FQ_PC_LD    = 1'b0;
            bus.FQ_PC_DIN   = {XLEN{1'b0}};
            bus.FQ_MEM_RDEN = 1'b0;
        end
        bus.FQ_OUT_VALID = out_valid_s;
        bus.FQ_OUT_INSTR = head_s.instr;
        bus.FQ_OUT_PC    = head_s.pc;
        bus.FQ_COUNT     = count_s;
    end

endmodule

// File: doc/otter_fetch_queue.md
# otter_fetch_queue

Instruction-fetch front end for the pipelined OTTER. It is the controlling end of the program-counter interface: it reads the current count, drives the counter's load/data inputs to advance or redirect it, and issues reads to the synchronous instruction memory. It buffers returned words with their addresses in a small queue. It presents them to decode with a valid/ready handshake, and flushes on a redirect from execute.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2.
- XLEN, 32, address/instruction width.

- FQ_CLK  in  1  rising-edge clock.
- FQ_RST_N  in  1  asynchronous, active-low reset.
- FQ_PC  in  XLEN  current program-counter value.
- FQ_PC_LD  out  1  load strobe to the program counter.
- FQ_PC_DIN  out  XLEN  value loaded into the program counter.
- FQ_MEM_RDEN  out  1  instruction-memory read enable; the address is FQ_PC.
- FQ_MEM_DOUT  in  XLEN  instruction word, valid the cycle after FQ_MEM_RDEN.
- FQ_REDIR  in  1  branch/jump taken in execute; flush and redirect.
- FQ_REDIR_ADDR  in  XLEN  redirect target.
- FQ_OUT_VALID  out  1  head entry valid.
- FQ_OUT_READY  in  1  decode accepts the head entry.
- FQ_OUT_INSTR  out  XLEN  head instruction.
- FQ_OUT_PC  out  XLEN  head instruction address.
- FQ_COUNT  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- State: circular queue (wr_ptr, rd_ptr, count), plus a pending register (pend_vld, pend_pc) for the one in-flight read.
- Issue condition: FQ_RST_N high, FQ_REDIR low, and count + pend_vld < DEPTH. This is conservative: a same-cycle pop is not counted.
- On issue:
  - FQ_MEM_RDEN=1, FQ_PC_LD=1, FQ_PC_DIN=FQ_PC+4 (mod 2^XLEN, wraps 0xFFFFFFFC→0).
  - pend_vld←1, pend_pc←FQ_PC.
  - With no issue, pend_vld←0.
- Push: when pend_vld=1 and FQ_REDIR=0, write {pend_pc, FQ_MEM_DOUT} at wr_ptr.
- Pop: when FQ_OUT_VALID && FQ_OUT_READY, advance rd_ptr.
  - A simultaneous push and pop leaves count unchanged.
  - A push into a full queue is impossible by the issue rule; assert this in simulation.
- FQ_OUT_VALID = (count≠0) && !FQ_REDIR. FQ_OUT_INSTR/FQ_OUT_PC show the head entry. They are don't-care when valid is low, but must not be X after reset.
- Redirect (FQ_REDIR=1):
  - FQ_PC_LD=1, FQ_PC_DIN={FQ_REDIR_ADDR[XLEN-1:2],2'b00}, with the low bits forced to zero.
  - No issue and no pop that cycle.
  - At the edge: count←0, rd_ptr=wr_ptr←0, pend_vld←0, so returning data is discarded.
  - Redirect overrides everything else, including a full queue or a concurrent pop attempt.
- Reset (asynchronous, any cycle, including mid-fetch):
  - count, pointers, and pend_vld clear to 0; storage clears to 0.
  - Outputs during reset: FQ_PC_LD=0, FQ_MEM_RDEN=0, FQ_OUT_VALID=0, FQ_PC_DIN=0, FQ_COUNT=0.
- The program counter's own reset is separate. After release, fetch starts from whatever FQ_PC holds.

## Timing
- Issue in cycle N with FQ_PC=A. The counter shows A+4 in N+1; the word for A arrives in N+1 and is pushed at the end of N+1; FQ_OUT_VALID is high in N+2.
- Fetch-to-decode latency is 2 cycles. Sustained throughput is 1 instruction/cycle with FQ_OUT_READY held high (steady state count=1, pend_vld=1).
- Redirect in cycle R: counter = target in R+1, first issue in R+1, first valid output in R+3.
- When decode stalls, issue stops once count + pend_vld reaches DEPTH. No word is ever dropped except by redirect.
- FQ_PC_LD, FQ_PC_DIN, FQ_MEM_RDEN and FQ_OUT_VALID are combinational from state and FQ_REDIR. All other state is registered.

## Structure
- Package otter_fetch_pkg:
  - XLEN default.
  - INSTR_BYTES=4.
  - NOP_INSTR=32'h00000013.
  - typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t.
- Sub-module otter_fetch_fifo: parameterised circular buffer of fetch_entry_t with push, pop, flush, count, and asynchronous active-low reset.
- The top level holds the issue and redirect control and the pending register.

## Test plan
- Reset release with FQ_PC=0x0, memory word at address a = a|0x100, READY=1 → outputs {pc,instr}: {0x0,0x100} at cycle 2, {0x4,0x104} at cycle 3, one per cycle thereafter.
- READY=0 from cycle 0 → FQ_COUNT saturates at 4, then RDEN=0 and PC_LD=0. READY=1 later → entries drain in order 0x0, 0x4, 0x8, 0xC, with no loss and no duplicates.
- FQ_REDIR=1 with FQ_REDIR_ADDR=0x203 while count=3 and pend_vld=1 → FQ_PC_DIN=0x200. The next cycle has count=0, and no stale entry appears. The first output is {0x200,…} three cycles after the redirect.
- FQ_PC=0xFFFFFFFC issue → FQ_PC_DIN=0x00000000, and the entry pc is 0xFFFFFFFC.
- FQ_RST_N pulled low mid-cycle with count=2 and pend_vld=1 → all outputs go to zero immediately. After release, the first output is for the FQ_PC value present then.
- Simultaneous pop and push at count=4, with READY toggled every cycle → count stays ≤4, the order is preserved, and the overflow assertion never fires.
